// File: rtl/nonce_result_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_result_encoder
//  Description : Writer side of the processor result path. Collects per-core
//                hit flags, selects the lowest-index winner once per block,
//                and drives its partition index with a one-cycle success
//                pulse. valid/newblock are forwarded with matching latency.
//                Hits are suppressed during the new-block broadcast window
//                and after a winner has been reported.
//  Options     : NONCE_RESULT_ENCODER_DROPCNT_EN builds the saturating count
//                of losing simultaneous hits; otherwise drop_cnt_o is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module nonce_result_encoder #(
   parameter int NUM_CORES     = 4,
   parameter int PARTITIONBITS = 4,
   parameter int BROADCAST_CNT = 5
) (
   input  logic                     clk,
   input  logic                     rst,          // asynchronous, active-low
   input  logic                     valid_i,
   input  logic                     newblock_i,
   input  logic [NUM_CORES-1:0]     hit_i,
   output logic [PARTITIONBITS-1:0] results_o_nonce_prefix,
   output logic                     results_o_success,
   output logic                     valid_o,
   output logic                     newblock_o,
   output logic [7:0]               drop_cnt_o
);

   // Broadcast counter only ever holds BROADCAST_CNT-1 down to 0.
   localparam int BC_W = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BCAST  = 2'd1;
   localparam logic [1:0] S_SEARCH = 2'd2;
   localparam logic [1:0] S_FOUND  = 2'd3;

   logic [1:0]               r_state;
   logic [1:0]               w_state_nxt;
   logic [BC_W-1:0]          r_bc;
   logic [BC_W-1:0]          w_bc_nxt;
   logic                     w_nb;
   logic                     w_accept;
   logic [PARTITIONBITS-1:0] w_winner;

   logic                     r_success;
   logic [PARTITIONBITS-1:0] r_prefix;
   logic                     r_valid;
   logic                     r_newblock;

   // A new block only counts when it arrives on a valid round.
   assign w_nb = valid_i & newblock_i;

   // Lowest set hit index wins; scanning downward lets the lowest overwrite.
   always_comb begin
      w_winner = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit_i[i]) begin
            w_winner = PARTITIONBITS'(i);
         end
      end
   end

   // State register: FSM state and broadcast counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_bc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_bc    <= w_bc_nxt;
      end
   end

   // Next-state logic: a valid new block overrides everything else.
   always_comb begin
      w_state_nxt = r_state;
      w_bc_nxt    = r_bc;
      if (w_nb) begin
         w_bc_nxt = BC_W'(BROADCAST_CNT - 1);
         if (BROADCAST_CNT == 1) begin
            w_state_nxt = S_SEARCH;
         end else begin
            w_state_nxt = S_BCAST;
         end
      end else if (valid_i) begin
         case (r_state)
            S_BCAST: begin
               w_bc_nxt = r_bc - BC_W'(1);
               if (r_bc == BC_W'(1)) begin
                  w_state_nxt = S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (|hit_i) begin
                  w_state_nxt = S_FOUND;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode: a hit is accepted only in SEARCH on a valid, non-newblock round.
   always_comb begin
      w_accept = (r_state == S_SEARCH) && valid_i && !newblock_i && (|hit_i);
   end

   // Registered result and forwarded strobes share the same one-cycle latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_success  <= 1'b0;
         r_prefix   <= '0;
         r_valid    <= 1'b0;
         r_newblock <= 1'b0;
      end else begin
         r_success  <= w_accept;
         r_valid    <= valid_i;
         r_newblock <= w_nb;
         if (w_accept) begin
            r_prefix <= w_winner;
         end
      end
   end

   assign results_o_success      = r_success;
   assign results_o_nonce_prefix = r_prefix;
   assign valid_o                = r_valid;
   assign newblock_o             = r_newblock;

`ifdef NONCE_RESULT_ENCODER_DROPCNT_EN
   logic [8:0] w_pop;
   logic [8:0] w_sum;
   logic [7:0] r_drop;

   // Count of simultaneous hits; the winner itself is subtracted later.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         w_pop = w_pop + 9'(hit_i[i]);
      end
      w_sum = {1'b0, r_drop} + w_pop - 9'd1;
   end

   // Drop counter: cleared on a new block, saturating accumulate on a win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drop <= '0;
      end else if (w_nb) begin
         r_drop <= '0;
      end else if (w_accept) begin
         r_drop <= w_sum[8] ? 8'hFF : w_sum[7:0];
      end
   end

   assign drop_cnt_o = r_drop;
`else
   assign drop_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonce_result_encoder
//  Description : Directed self-checking bench for nonce_result_encoder with
//                NUM_CORES=4, PARTITIONBITS=4, BROADCAST_CNT=5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_result_encoder;

`ifdef NONCE_RESULT_ENCODER_DROPCNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       valid_i;
   logic       newblock_i;
   logic [3:0] hit_i;
   logic [3:0] nonce_prefix;
   logic       success;
   logic       valid_o;
   logic       newblock_o;
   logic [7:0] drop_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   nonce_result_encoder #(
      .NUM_CORES    (4),
      .PARTITIONBITS(4),
      .BROADCAST_CNT(5)
   ) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .valid_i               (valid_i),
      .newblock_i            (newblock_i),
      .hit_i                 (hit_i),
      .results_o_nonce_prefix(nonce_prefix),
      .results_o_success     (success),
      .valid_o               (valid_o),
      .newblock_o            (newblock_o),
      .drop_cnt_o            (drop_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one round, let it be sampled, and look 1 time unit after the edge.
   task automatic step(input logic v, input logic nb, input logic [3:0] h);
      valid_i    = v;
      newblock_i = nb;
      hit_i      = h;
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input logic v, input logic nb,
                           input logic [3:0] h, input logic exp_s);
      step(v, nb, h);
      check_eq({tag, ".success"}, 32'(success), 32'(exp_s));
      check_eq({tag, ".valid_o"}, 32'(valid_o), 32'(v));
      check_eq({tag, ".newblock_o"}, 32'(newblock_o), 32'(v & nb));
   endtask

   // New block plus the four further window rounds, all with hit pattern h.
   task automatic open_block(input string tag, input logic [3:0] h);
      step_chk({tag, ".nb"}, 1'b1, 1'b1, h, 1'b0);
      check_eq({tag, ".drop_clr"}, 32'(drop_cnt_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step_chk({tag, ".win"}, 1'b1, 1'b0, h, 1'b0);
      end
   endtask

   initial begin
      rst        = 1'b0;
      valid_i    = 1'b0;
      newblock_i = 1'b0;
      hit_i      = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.success", 32'(success), 32'd0);
      check_eq("rst.prefix", 32'(nonce_prefix), 32'd0);
      check_eq("rst.valid_o", 32'(valid_o), 32'd0);
      check_eq("rst.newblock_o", 32'(newblock_o), 32'd0);
      check_eq("rst.drop", 32'(drop_cnt_o), 32'd0);
      rst = 1'b1;
      step_chk("idle_quiet", 1'b0, 1'b0, 4'b0000, 1'b0);
      check_eq("idle.prefix", 32'(nonce_prefix), 32'd0);

      // IDLE ignores hits
      step_chk("idle_hit", 1'b1, 1'b0, 4'b0001, 1'b0);

      // Broadcast window: five valid rounds suppressed, sixth accepted
      open_block("bcast", 4'b0100);
      step_chk("bcast.last", 1'b1, 1'b0, 4'b0100, 1'b1);
      check_eq("bcast.prefix", 32'(nonce_prefix), 32'd2);
      check_eq("bcast.drop", 32'(drop_cnt_o), 32'd0);
      step_chk("bcast.pulse", 1'b1, 1'b0, 4'b0000, 1'b0);
      check_eq("bcast.hold", 32'(nonce_prefix), 32'd2);

      // Simultaneous hits: lowest index wins, one loser counted
      open_block("simul", 4'b0000);
      step_chk("simul.hit", 1'b1, 1'b0, 4'b1010, 1'b1);
      check_eq("simul.prefix", 32'(nonce_prefix), 32'd1);
      check_eq("simul.drop", 32'(drop_cnt_o), DROP_EN ? 32'd1 : 32'd0);
      step_chk("simul.pulse", 1'b1, 1'b0, 4'b0000, 1'b0);

      // Post-win suppression
      step_chk("found.hit", 1'b1, 1'b0, 4'b0001, 1'b0);
      check_eq("found.prefix", 32'(nonce_prefix), 32'd1);
      check_eq("found.drop", 32'(drop_cnt_o), DROP_EN ? 32'd1 : 32'd0);

      // Rearm: new block clears drop count, new winner reported
      open_block("rearm", 4'b0000);
      step_chk("rearm.hit", 1'b1, 1'b0, 4'b1000, 1'b1);
      check_eq("rearm.prefix", 32'(nonce_prefix), 32'd3);
      check_eq("rearm.drop", 32'(drop_cnt_o), 32'd0);

      // All four cores hit: winner 0, three losers
      open_block("all", 4'b0000);
      step_chk("all.hit", 1'b1, 1'b0, 4'b1111, 1'b1);
      check_eq("all.prefix", 32'(nonce_prefix), 32'd0);
      check_eq("all.drop", 32'(drop_cnt_o), DROP_EN ? 32'd3 : 32'd0);

      // Valid gating in SEARCH; newblock with valid low ignored
      open_block("gate", 4'b0000);
      step_chk("gate.inval_hit", 1'b0, 1'b0, 4'b1111, 1'b0);
      step_chk("gate.inval_nb", 1'b0, 1'b1, 4'b0000, 1'b0);
      step_chk("gate.hit", 1'b1, 1'b0, 4'b0100, 1'b1);
      check_eq("gate.prefix", 32'(nonce_prefix), 32'd2);

      // Stall mid-broadcast extends the window by the stalled rounds
      step_chk("stall.nb", 1'b1, 1'b1, 4'b0001, 1'b0);
      step_chk("stall.w2", 1'b1, 1'b0, 4'b0001, 1'b0);
      step_chk("stall.w3", 1'b1, 1'b0, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step_chk("stall.idle", 1'b0, 1'b0, 4'b0001, 1'b0);
      end
      step_chk("stall.w4", 1'b1, 1'b0, 4'b0001, 1'b0);
      step_chk("stall.w5", 1'b1, 1'b0, 4'b0001, 1'b0);
      step_chk("stall.hit", 1'b1, 1'b0, 4'b0001, 1'b1);
      check_eq("stall.prefix", 32'(nonce_prefix), 32'd0);

      // New block and hits together in SEARCH: new block wins
      open_block("nbhit.setup", 4'b0000);
      step_chk("nbhit.nb", 1'b1, 1'b1, 4'b0010, 1'b0);
      check_eq("nbhit.prefix", 32'(nonce_prefix), 32'd0);
      check_eq("nbhit.drop", 32'(drop_cnt_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step_chk("nbhit.win", 1'b1, 1'b0, 4'b0010, 1'b0);
      end
      step_chk("nbhit.hit", 1'b1, 1'b0, 4'b0010, 1'b1);
      check_eq("nbhit.prefix2", 32'(nonce_prefix), 32'd1);

      // Reset while a SEARCH hit is pending: no success, back to IDLE
      open_block("rmid", 4'b0000);
      valid_i    = 1'b1;
      newblock_i = 1'b0;
      hit_i      = 4'b0100;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rmid.async_prefix", 32'(nonce_prefix), 32'd0);
      @(posedge clk);
      #1;
      check_eq("rmid.success", 32'(success), 32'd0);
      check_eq("rmid.valid_o", 32'(valid_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step_chk("rmid.idle_hit", 1'b1, 1'b0, 4'b0100, 1'b0);
      step_chk("rmid.idle_hit2", 1'b1, 1'b0, 4'b0100, 1'b0);
      open_block("rmid.reopen", 4'b0000);
      step_chk("rmid.hit", 1'b1, 1'b0, 4'b0100, 1'b1);
      check_eq("rmid.prefix", 32'(nonce_prefix), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
